// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM receiver constants, FSM state type and bit-reverse helper
//
// Purpose : default symbol geometry, sample field slices, read FSM state
//           encoding and an index bit-reversal function for DIT FFT ordering.
// Ports   : none (package).
package ofdm_pkg;

  localparam int NFFT      = 2048;
  localparam int LOG2N     = 11;
  localparam int DW        = 32;
  localparam int MAX_LOG2N = 16;

  // Sample layout {re, im}, both 16-bit two's complement.
  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2,
    RD_GAP    = 2'd3
  } rd_state_e;

  // Reverses the low 'width' bits of idx; bits at and above 'width' come back zero.
  function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] idx,
                                                   input int width);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < width) r[width-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofdm_dpram.sv
// rtl/ofdm_dpram.sv - simple dual-port RAM, one write port, one registered read port
//
// Purpose : symbol storage for both ping-pong banks; maps onto block RAM.
// Ports   : clk    in  clock
//           rst_n  in  asynchronous active-low reset of the read data register only
//           we     in  write enable
//           waddr  in  write address
//           wdata  in  write data
//           raddr  in  read address, sampled every cycle
//           rdata  out registered read data
module ofdm_dpram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  import ofdm_pkg::*;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is cleared so the downstream data bus reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_in_buffer.sv
// rtl/fft_in_buffer.sv - ping-pong symbol buffer between CP remover and FFT core
//
// Purpose : collects NFFT samples per symbol into one of two banks (optionally in
//           bit-reversed order) and replays each full bank as one CYC_O burst.
// Ports   : CLK_I in clock;  RST_I in async active-low reset
//           DAT_I/WE_I/STB_I/CYC_I in, ACK_O out : sample input handshake
//           DAT_O/CYC_O/STB_O/WE_O out, ACK_I in : symbol burst to the FFT
module fft_in_buffer #(
  parameter int NFFT   = ofdm_pkg::NFFT,
  parameter int LOG2N  = ofdm_pkg::LOG2N,
  parameter int DW     = ofdm_pkg::DW,
  parameter bit BITREV = 1'b0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
);
  import ofdm_pkg::*;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(NFFT - 1);

  logic [LOG2N-1:0]     wr_cnt, wr_idx;
  logic [LOG2N-1:0]     rd_cnt, rd_idx;
  logic [MAX_LOG2N-1:0] wr_rev;
  logic                 wr_bank, rd_bank;
  logic [1:0]           full, full_set, full_clr;
  logic                 wr_en, wr_last, rd_release;
  logic                 cyc, stb;
  rd_state_e            state, next_state;

  // ---------------- write side ----------------
  assign wr_rev = bit_rev(MAX_LOG2N'(wr_cnt), LOG2N);
  assign wr_idx = BITREV ? wr_rev[LOG2N-1:0] : wr_cnt;

  // Gated by reset so ACK_O is low while reset is held, even with a free bank.
  assign wr_en   = RST_I & CYC_I & STB_I & WE_I & ~full[wr_bank];
  assign ACK_O   = wr_en;
  assign wr_last = wr_en && (wr_cnt == LAST);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
    end else if (!CYC_I) begin
      wr_cnt <= '0;
    end
  end

  // ---------------- bank flags ----------------
  // Fill and release always target different banks, so both may apply in one cycle.
  assign rd_release = (state == RD_STREAM) && ACK_I && (rd_cnt == LAST);
  assign full_set   = wr_last    ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr   = rd_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) full <= 2'b00;
    else        full <= (full | full_set) & ~full_clr;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= RD_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      if ((state == RD_STREAM) && ACK_I) rd_cnt <= rd_cnt + 1'b1;
      if (rd_release) rd_bank <= ~rd_bank;
    end
  end

  // The RAM read port is always active: during STREAM it looks one word ahead on
  // ACK_I and re-reads the current word otherwise, so DAT_O holds under backpressure.
  always_comb begin
    next_state = state;
    rd_idx     = rd_cnt;
    cyc        = 1'b0;
    stb        = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) next_state = RD_PRIME;
      end
      RD_PRIME: begin
        cyc        = 1'b1;
        rd_idx     = '0;
        next_state = RD_STREAM;
      end
      RD_STREAM: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (ACK_I) rd_idx = rd_cnt + 1'b1;
        if (rd_release) next_state = RD_GAP;
      end
      RD_GAP: begin
        next_state = RD_IDLE;
      end
      default: next_state = RD_IDLE;
    endcase
  end

  assign CYC_O = cyc;
  assign STB_O = stb;
  assign WE_O  = stb;

  ofdm_dpram #(
    .AW (LOG2N + 1),
    .DW (DW)
  ) u_ram (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .we    (wr_en),
    .waddr ({wr_bank, wr_idx}),
    .wdata (DAT_I),
    .raddr ({rd_bank, rd_idx}),
    .rdata (DAT_O)
  );

endmodule

// File: tb/tb_fft_in_buffer.sv
// tb/tb_fft_in_buffer.sv - directed self-checking bench for fft_in_buffer
module tb_fft_in_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] dat_i;
  logic        we_i, stb_i, cyc_i, ack_i;
  logic        ack_o_n, cyc_o_n, stb_o_n, we_o_n;
  logic        ack_o_r, cyc_o_r, stb_o_r, we_o_r;
  logic [31:0] dat_o_n, dat_o_r;

  int          tests_run;
  int          failed;
  int          wr_accepted;
  int          stb_cycles;
  int          first_stb_iter;
  logic        post_cyc;
  logic        post_ack;
  logic [31:0] got[$];

  fft_in_buffer #(.NFFT(64), .LOG2N(6), .DW(32), .BITREV(1'b0)) dut_n (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i),
    .ACK_O(ack_o_n), .DAT_O(dat_o_n), .CYC_O(cyc_o_n), .STB_O(stb_o_n), .WE_O(we_o_n),
    .ACK_I(ack_i)
  );

  fft_in_buffer #(.NFFT(64), .LOG2N(6), .DW(32), .BITREV(1'b1)) dut_r (
    .CLK_I(clk), .RST_I(rst_n), .DAT_I(dat_i), .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i),
    .ACK_O(ack_o_r), .DAT_O(dat_o_r), .CYC_O(cyc_o_r), .STB_O(stb_o_r), .WE_O(we_o_r),
    .ACK_I(ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev6(input int j);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (j[b]) r = r | (1 << (5 - b));
    return r;
  endfunction

  task automatic write_words(input int first, input int n, input bit keep_cyc);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 32'(first + i);
      #1;
      t = 0;
      while (ack_o_n !== 1'b1 && t < 400) begin
        @(negedge clk); #1; t++;
      end
      if (t >= 400) begin
        tests_run++; failed++;
        $display("FAIL write_timeout word=%0d ack_o=%b required 1", first + i, ack_o_n);
        stb_i = 1'b0; we_i = 1'b0; cyc_i = 1'b0;
        return;
      end
      @(posedge clk);
      wr_accepted++;
    end
    @(negedge clk);
    stb_i = 1'b0; we_i = 1'b0;
    if (!keep_cyc) cyc_i = 1'b0;
  endtask

  // mode 0: ACK_I always 1; mode 1: ACK_I alternates 1,0,1,0 over STB_O cycles
  task automatic collect(input int n, input int mode, input bit sel);
    logic        stb, prev_stb, prev_ack, a, tog;
    logic [31:0] d, prev_d;
    int          it;
    got.delete();
    stb_cycles = 0; first_stb_iter = -1;
    prev_stb = 1'b0; prev_ack = 1'b0; prev_d = '0; tog = 1'b1; it = 0;
    while (got.size() < n && it < 2000) begin
      @(negedge clk); #2;
      stb = sel ? stb_o_r : stb_o_n;
      d   = sel ? dat_o_r : dat_o_n;
      a   = (mode == 0) ? 1'b1 : tog;
      if (stb) begin
        stb_cycles++;
        if (first_stb_iter < 0) first_stb_iter = it;
        if (prev_stb && !prev_ack) begin
          tests_run++;
          if (d !== prev_d) begin
            failed++;
            $display("FAIL hold_dat_o got=%0d required=%0d", d, prev_d);
          end
        end
        if (mode == 1) tog = ~tog;
        if (a) got.push_back(d);
      end
      ack_i = a;
      prev_stb = stb; prev_ack = a; prev_d = d;
      it++;
    end
    if (got.size() < n) begin
      tests_run++; failed++;
      $display("FAIL collect_timeout words=%0d required=%0d", got.size(), n);
    end
    @(negedge clk); #2;
    ack_i = 1'b0;
    post_cyc = sel ? cyc_o_r : cyc_o_n;
    post_ack = ack_o_n;
  endtask

  task automatic check_seq(input string name, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (i >= got.size() || got[i] !== 32'(base + i)) begin
        failed++;
        $display("FAIL %s idx=%0d got=%0d required=%0d", name, i,
                 (i < got.size()) ? got[i] : 32'hffffffff, base + i);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; ack_i = 1'b0;
    dat_i = 32'hdead_beef;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({ack_o_n, cyc_o_n, stb_o_n, we_o_n} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_ctrl got=%b required=0000", {ack_o_n, cyc_o_n, stb_o_n, we_o_n});
    end
    tests_run++;
    if (dat_o_n !== 32'd0 || dat_o_r !== 32'd0) begin
      failed++;
      $display("FAIL reset_dat got=%h/%h required=0", dat_o_n, dat_o_r);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_linear;
    write_words(0, 64, 0);
    #2;
    tests_run++;
    if (cyc_o_n !== 1'b0) begin
      failed++; $display("FAIL latency_k cyc_o=%b required 0", cyc_o_n);
    end
    @(negedge clk); #2;
    tests_run++;
    if ({cyc_o_n, stb_o_n, we_o_n} !== 3'b100) begin
      failed++; $display("FAIL latency_prime cyc/stb/we=%b required 100", {cyc_o_n, stb_o_n, we_o_n});
    end
    collect(64, 0, 0);
    tests_run++;
    if (first_stb_iter !== 0) begin
      failed++; $display("FAIL first_stb iter=%0d required 0", first_stb_iter);
    end
    tests_run++;
    if (stb_cycles !== 64) begin
      failed++; $display("FAIL stb_cycles got=%0d required 64", stb_cycles);
    end
    check_seq("linear_data", 0, 64);
    tests_run++;
    if (post_cyc !== 1'b0) begin
      failed++; $display("FAIL gap_cyc got=%b required 0", post_cyc);
    end
  endtask

  task automatic test_bitrev;
    write_words(0, 64, 0);
    collect(64, 0, 1);
    for (int j = 0; j < 64; j++) begin
      tests_run++;
      if (j >= got.size() || got[j] !== 32'(rev6(j))) begin
        failed++;
        $display("FAIL bitrev idx=%0d got=%0d required=%0d", j,
                 (j < got.size()) ? got[j] : 32'hffffffff, rev6(j));
      end
    end
  endtask

  task automatic test_backpressure;
    write_words(200, 64, 0);
    collect(64, 1, 0);
    check_seq("bp_data", 200, 64);
    tests_run++;
    if (stb_cycles !== 127) begin
      failed++; $display("FAIL bp_stb_cycles got=%0d required 127", stb_cycles);
    end
  endtask

  task automatic test_stall;
    ack_i = 1'b0;
    wr_accepted = 0;
    fork
      write_words(300, 130, 1);
      begin
        int t;
        t = 0;
        while (wr_accepted < 128 && t < 500) begin
          @(negedge clk); #2; t++;
        end
        for (int c = 0; c < 3; c++) begin
          tests_run++;
          if (ack_o_n !== 1'b0 || wr_accepted !== 128) begin
            failed++;
            $display("FAIL stall ack_o=%b accepted=%0d required 0/128", ack_o_n, wr_accepted);
          end
          @(negedge clk); #2;
        end
        collect(64, 0, 0);
        check_seq("stall_bank0", 300, 64);
        tests_run++;
        if (post_ack !== 1'b1) begin
          failed++; $display("FAIL ack_after_release got=%b required 1", post_ack);
        end
        collect(64, 0, 0);
        check_seq("stall_bank1", 364, 64);
      end
    join
    write_words(430, 62, 0);
    collect(64, 0, 0);
    check_seq("stall_tail", 428, 64);
  endtask

  task automatic test_abort;
    logic seen;
    write_words(500, 20, 0);
    write_words(100, 64, 0);
    collect(64, 0, 0);
    check_seq("abort_data", 100, 64);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #2;
      if (stb_o_n) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      failed++; $display("FAIL abort_extra_burst stb seen=%b required 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    write_words(600, 64, 0);
    collect(10, 0, 0);
    check_seq("pre_reset", 600, 10);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 32'h1234_5678;
    #1;
    tests_run++;
    if (stb_o_n !== 1'b1) begin
      failed++; $display("FAIL pre_reset_stream stb_o=%b required 1", stb_o_n);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cyc_o_n, stb_o_n, ack_o_n, we_o_n} !== 4'b0000 || dat_o_n !== 32'd0) begin
      failed++;
      $display("FAIL reset_mid cyc/stb/ack/we=%b dat=%h required 0000/0",
               {cyc_o_n, stb_o_n, ack_o_n, we_o_n}, dat_o_n);
    end
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    rst_n = 1'b1;
    write_words(700, 64, 0);
    collect(64, 0, 0);
    check_seq("post_reset", 700, 64);
  endtask

  initial begin
    tests_run = 0; failed = 0; wr_accepted = 0;
    test_reset;
    test_linear;
    test_bitrev;
    test_backpressure;
    test_stall;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
